// File: rtl/demux2a8_dispatch_pkg.sv
// Shared types for the four-lane result dispatcher: channel count, select type and slot states.
package demux2a8_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] chan_sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_st_t;

    // One-hot decode of a channel select into a per-channel enable vector.
    function automatic logic [NCH-1:0] sel_onehot(input chan_sel_t sel);
        return NCH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux2a8_dispatch_if.sv
// Handshake bus of the dispatcher: one valid/ready input lane and four valid/ready output lanes.
interface demux2a8_dispatch_if #(
    parameter int WIDTH = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux2a8_dispatch_slot.sv
// One-entry register slot holding a single beat for one output lane, with load and drain.
module demux_slot
    import demux2a8_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    slot_st_t         state;
    slot_st_t         state_nxt;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // The upstream ready logic only lets a load through when the slot is empty
    // or draining this cycle, so a load always leaves the slot full.
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (drain_ready && !load) state_nxt = SLOT_EMPTY;
            default:    state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign valid = (state == SLOT_FULL);
    assign data  = data_q;

endmodule

// File: rtl/demux2a8_dispatch.sv
// Routes one WIDTH-bit beat to one of four registered output lanes chosen by a 2-bit select.
// Optional per-lane saturating transfer counters are enabled with DISPATCH_CNT_EN.
module demux2a8_dispatch
    import demux2a8_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux2a8_dispatch_if.slave     bus,
    output logic                   busy
`ifdef DISPATCH_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0]   cnt
`endif
);

    logic                   ready_en;
    logic                   accept;
    logic [NCH-1:0]         load_vec;
    logic [NCH-1:0]         valid_vec;
    logic [NCH*WIDTH-1:0]   data_vec;

    // Holds in_ready low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign bus.in_ready = ready_en && (!valid_vec[bus.in_sel] || bus.out_ready[bus.in_sel]);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_vec     = accept ? sel_onehot(chan_sel_t'(bus.in_sel)) : '0;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (load_vec[k]),
            .load_data   (bus.in_data),
            .drain_ready (bus.out_ready[k]),
            .valid       (valid_vec[k]),
            .data        (data_vec[k*WIDTH +: WIDTH])
        );
    end

    assign bus.out_valid = valid_vec;
    assign bus.out_data  = data_vec;
    assign busy          = |valid_vec;

`ifdef DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];

    // Counts completed output handshakes per lane, sticking at all-ones.
    for (genvar k = 0; k < NCH; k++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[k] <= '0;
            end else if (valid_vec[k] && bus.out_ready[k] && (cnt_q[k] != '1)) begin
                cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
        assign cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_demux2a8_dispatch.sv
// Directed self-checking bench for demux2a8_dispatch (counter test runs only with DISPATCH_CNT_EN).
module tb_demux2a8_dispatch;

    logic clk;
    logic rst_n;
    logic busy;
    int   total;
    int   bad;
`ifdef DISPATCH_CNT_EN
    logic [31:0] cnt;
`endif

    demux2a8_dispatch_if #(.WIDTH(2)) bus ();

    demux2a8_dispatch #(
        .WIDTH(2),
        .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef DISPATCH_CNT_EN
        ,
        .cnt   (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [1:0] d,
                                 input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] route_data [4];
        logic [1:0] refill_data [5];
        route_data  = '{2'b01, 2'b10, 2'b11, 2'b00};
        refill_data = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01};
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b0000);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);

        // Release mid-cycle: ready must wait for the next rising edge.
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checkOutput("rel_in_ready_pre", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("rel_in_ready_post", 32'(bus.in_ready), 32'h1);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'(k), route_data[k], 4'b1111);
            tick();
            checkOutput($sformatf("route_valid_%0d", k), 32'(bus.out_valid), 32'(4'b0001 << k));
            checkOutput($sformatf("route_data_%0d", k), 32'(bus.out_data[k*2 +: 2]),
                        32'(route_data[k]));
        end
        checkOutput("route_all_data", 32'(bus.out_data), 32'h39);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checkOutput("route_drained", 32'(bus.out_valid), 32'h0);
        checkOutput("route_busy", 32'(busy), 32'h0);

        applyStimulus(1'b1, 2'd2, 2'b11, 4'b1011);
        checkOutput("bp_ready_first", 32'(bus.in_ready), 32'h1);
        tick();
        checkOutput("bp_valid_first", 32'(bus.out_valid), 32'h4);
        checkOutput("bp_data_first", 32'(bus.out_data[5:4]), 32'h3);
        applyStimulus(1'b1, 2'd2, 2'b01, 4'b1011);
        checkOutput("bp_ready_stall", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'h4);
        checkOutput("bp_hold_data", 32'(bus.out_data[5:4]), 32'h3);
        applyStimulus(1'b1, 2'd2, 2'b01, 4'b1111);
        checkOutput("bp_ready_release", 32'(bus.in_ready), 32'h1);
        tick();
        checkOutput("bp_second_valid", 32'(bus.out_valid), 32'h4);
        checkOutput("bp_second_data", 32'(bus.out_data[5:4]), 32'h1);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checkOutput("bp_drained", 32'(bus.out_valid), 32'h0);

        // Lane 1 stalled and full must not block a beat for lane 3.
        applyStimulus(1'b1, 2'd1, 2'b01, 4'b0000);
        tick();
        applyStimulus(1'b1, 2'd3, 2'b10, 4'b0000);
        checkOutput("ind_ready", 32'(bus.in_ready), 32'h1);
        tick();
        checkOutput("ind_valid", 32'(bus.out_valid), 32'ha);
        checkOutput("ind_ch1_data", 32'(bus.out_data[3:2]), 32'h1);
        checkOutput("ind_ch3_data", 32'(bus.out_data[7:6]), 32'h2);
        applyStimulus(1'b1, 2'd1, 2'b11, 4'b0000);
        checkOutput("ind_ch1_stall", 32'(bus.in_ready), 32'h0);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checkOutput("ind_drained", 32'(bus.out_valid), 32'h0);

        applyStimulus(1'b1, 2'd0, 2'b11, 4'b1111);
        tick();
        checkOutput("refill_prefill", 32'(bus.out_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd0, refill_data[i], 4'b1111);
            checkOutput($sformatf("refill_ready_%0d", i), 32'(bus.in_ready), 32'h1);
            tick();
            checkOutput($sformatf("refill_valid_%0d", i), 32'(bus.out_valid), 32'h1);
            checkOutput($sformatf("refill_data_%0d", i), 32'(bus.out_data[1:0]),
                        32'(refill_data[i]));
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checkOutput("refill_drained", 32'(bus.out_valid), 32'h0);

        // A held beat is discarded by a mid-cycle reset.
        applyStimulus(1'b1, 2'd2, 2'b10, 4'b0000);
        tick();
        applyStimulus(1'b0, 2'd2, 2'd0, 4'b0000);
        checkOutput("mrst_held", 32'(bus.out_valid), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mrst_valid", 32'(bus.out_valid), 32'h0);
        checkOutput("mrst_data", 32'(bus.out_data), 32'h0);
        checkOutput("mrst_busy", 32'(busy), 32'h0);
        checkOutput("mrst_in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checkOutput("mrst_ready_after", 32'(bus.in_ready), 32'h1);
        checkOutput("mrst_no_replay", 32'(bus.out_valid), 32'h0);

`ifdef DISPATCH_CNT_EN
        applyStimulus(1'b1, 2'd3, 2'b01, 4'b1111);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        applyStimulus(1'b0, 2'd0, 2'd0, 4'b1111);
        tick();
        checkOutput("cnt_ch3_sat", 32'(cnt[31:24]), 32'hff);
        checkOutput("cnt_others", 32'(cnt[23:0]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
